// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and the
// memory-operation decode used by the memory stage.
package y86_pkg;

    localparam logic [3:0] IHALT    = 4'h0;
    localparam logic [3:0] INOP     = 4'h1;
    localparam logic [3:0] IRRMOVQ  = 4'h2;
    localparam logic [3:0] IIRMOVQ  = 4'h3;
    localparam logic [3:0] IRMMOVQ  = 4'h4;
    localparam logic [3:0] IMRMOVQ  = 4'h5;
    localparam logic [3:0] IOPQ     = 4'h6;
    localparam logic [3:0] IJXX     = 4'h7;
    localparam logic [3:0] ICALL    = 4'h8;
    localparam logic [3:0] IRET     = 4'h9;
    localparam logic [3:0] IPUSHQ   = 4'hA;
    localparam logic [3:0] IPOPQ    = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    typedef enum logic [1:0] {
        MEM_NONE,
        MEM_RD,
        MEM_WR
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [3:0] icode);
        case (icode)
            IRMMOVQ, ICALL, IPUSHQ: decode_op = MEM_WR;
            IMRMOVQ, IRET, IPOPQ:   decode_op = MEM_RD;
            default:                decode_op = MEM_NONE;
        endcase
    endfunction

    // ret/popq address the stack through valA; everything else uses valE.
    function automatic logic addr_from_vala(input logic [3:0] icode);
        addr_from_vala = (icode == IRET) || (icode == IPOPQ);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data memory: single port, synchronous write,
// combinational read, no reset.
module dmem_array #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    output logic [63:0]       rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: start/done handshake around a LATENCY-cycle access
// to dmem_array. Define MEM_ADR_CHECK_EN to report out-of-range addresses as ADR.
module mem_stage
    import y86_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        icode,
    input  logic [63:0]       valE,
    input  logic [63:0]       valA,
    input  logic [63:0]       valP,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [63:0]       ld_data,
    output logic              busy,
    output logic              done,
    output logic [63:0]       valM,
    output logic [1:0]        stat
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    mem_op_t           op;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wdata;

    mem_op_t           req_op;
    logic [63:0]       req_addr;
    logic [63:0]       req_wdata;
    logic              req_in_range;
    logic              req_bad;
    logic              last_access;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;

    assign req_op       = decode_op(icode);
    assign req_addr     = addr_from_vala(icode) ? valA : valE;
    assign req_wdata    = (icode == ICALL) ? valP : valA;
    assign req_in_range = req_addr < 64'(DEPTH);

`ifdef MEM_ADR_CHECK_EN
    assign req_bad = (req_op != MEM_NONE) && !req_in_range;
`else
    // Addresses wrap modulo DEPTH, so the range result is deliberately unused.
    logic unused_range;
    assign unused_range = req_in_range;
    assign req_bad      = 1'b0;
`endif

    assign last_access = (state == S_ACCESS) && (cnt == '0);

    // The single port is shared: preload owns it in IDLE, the latched op otherwise.
    assign mem_we    = !rst && (((state == S_IDLE) && !start && ld_en) ||
                                (last_access && (op == MEM_WR)));
    assign mem_addr  = (state == S_IDLE) ? ld_addr : addr;
    assign mem_wdata = (state == S_IDLE) ? ld_data : wdata;

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            op    <= MEM_NONE;
            addr  <= '0;
            wdata <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            valM  <= '0;
            stat  <= STAT_AOK;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        addr  <= req_addr[ADDR_W-1:0];
                        wdata <= req_wdata;
                        cnt   <= CNT_W'(LATENCY - 1);
                        busy  <= 1'b1;
                        if ((req_op != MEM_NONE) && !req_bad) begin
                            op    <= req_op;
                            stat  <= STAT_AOK;
                            state <= S_ACCESS;
                            if (req_op == MEM_WR) begin
                                valM <= '0;
                            end
                        end else begin
                            op    <= MEM_NONE;
                            valM  <= '0;
                            done  <= 1'b1;
                            state <= S_DONE;
                            if (req_bad) begin
                                stat <= STAT_ADR;
                            end else if (icode == IHALT) begin
                                stat <= STAT_HLT;
                            end else if (icode >= 4'hC) begin
                                stat <= STAT_INS;
                            end else begin
                                stat <= STAT_AOK;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (cnt == '0) begin
                        if (op == MEM_RD) begin
                            valM <= mem_rdata;
                        end
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the sequential Y86-64 core; sits directly downstream of Execute and consumes its valE together with the decoded valA/valP.
- Owns the word-addressed data memory: one 64-bit word per address, so the stack steps by 1.
- Performs the per-instruction read or write under a start/done handshake with the top-level sequencer.
- Produces valM and the instruction status stat.

Parameters:
- DEPTH, 256, number of 64-bit words in data memory.
- ADDR_W, 8, index width; DEPTH == 2**ADDR_W.
- LATENCY, 2, cycles spent in ACCESS per memory operation; must be >= 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- icode  in  4  instruction code of the current instruction.
- valE  in  64  Execute result; address for rmmovq/mrmovq/call/pushq.
- valA  in  64  write data for rmmovq/pushq; address for ret/popq.
- valP  in  64  write data for call.
- ld_en  in  1  preload write strobe; honoured only in IDLE without start.
- ld_addr  in  ADDR_W  preload address.
- ld_data  in  64  preload data.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; valM and stat are valid in that cycle and held afterwards.
- valM  out  64  read data; 0 for non-read instructions.
- stat  out  2  status: AOK=0, HLT=1, ADR=2, INS=3.

Behaviour:
- Reset values: state IDLE, busy=0, done=0, valM=0, stat=AOK.
- Reset is synchronous and overrides everything, including mid-operation.
  - A write not yet committed is dropped.
  - The memory array is never cleared by reset.
- Opcode map, decided at start:
  - 4 rmmovq: write M[valE] <- valA.
  - 5 mrmovq: read M[valE].
  - 8 call: write M[valE] <- valP.
  - 9 ret: read M[valA].
  - A pushq: write M[valE] <- valA.
  - B popq: read M[valA].
  - 0 halt: no access, stat=HLT.
  - 1,2,3,6,7: no access, stat=AOK.
  - C-F: no access, stat=INS.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, start=1 at edge T: latch icode, address, write data and operation.
  - Memory op with valid address: go to ACCESS.
  - Otherwise: go straight to DONE; done is asserted in cycle T+1.
- ACCESS holds for exactly LATENCY cycles, counted by a down-counter.
  - Write: commits only on the last ACCESS cycle.
  - Read: data is captured into valM on the last ACCESS cycle.
  - Then go to DONE; done is asserted in cycle T+LATENCY+1.
- DONE: done=1 for one cycle, then IDLE. The next start is accepted in the cycle after DONE.
- start while busy is ignored, not queued.
- Address check: the 64-bit address is in range iff addr < DEPTH (unsigned); behaviour on an out-of-range address is set by the optional feature.
- valM is cleared to 0 on acceptance of any non-read instruction.
- Preload: in IDLE with start=0, ld_en=1 writes M[ld_addr] <- ld_data at the edge. If start and ld_en are high in the same cycle, start wins and the preload is dropped.

Optional Feature:
- Macro: MEM_ADR_CHECK_EN.
- Defined: an out-of-range address skips ACCESS, performs no write, returns valM=0 and stat=ADR, and done is asserted at T+1.
- Undefined: the address is truncated to its low ADR_W bits (wraps modulo DEPTH), the access proceeds normally and stat=AOK.

Decomposition:
- Shared package y86_pkg:
  - icode constants (IHALT..IPOPQ).
  - stat codes (STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS).
  - mem_op enum (NONE, RD, WR).
- One sub-module, dmem_array: single-port, synchronous write, combinational read, no reset.
- The FSM, counter and address check stay in mem_stage.

Test Plan:
- Preload M[5]=0x1234; start mrmovq with valE=5, LATENCY=2 -> done at T+3, valM=0x1234, stat=AOK, busy high for 3 cycles.
- pushq with valE=0x10, valA=0xDEAD; then popq with valA=0x10 -> second done gives valM=0xDEAD.
- call with valE=0xFF, valP=0x40; then ret with valA=0xFF -> valM=0x40. With DEPTH=256, address 0xFF is in range.
- rmmovq with valE=0x100:
  - MEM_ADR_CHECK_EN defined -> done at T+1, stat=ADR, M[0] unchanged.
  - Undefined -> M[0]=valA, stat=AOK.
- halt -> done at T+1, stat=HLT. icode=0xC -> stat=INS. OPq (icode 6) -> stat=AOK, valM=0.
- rst asserted during the first ACCESS cycle of rmmovq M[7]<-0x99 -> next cycle busy=0, done=0, stat=AOK, M[7] keeps its old value. A start pulsed while busy is ignored.
